// File: rtl/bigmul_unit_csa.sv
// Multi-cycle big-integer multiplier: R = A * B over 64-bit limbs, PARALLEL limb products per
// cycle into carry-save column accumulators, then one serial carry-propagate pass.
// Define BIGMUL_CYCLE_CNT_EN to build the busy-cycle counter behind cycles_out.
`timescale 1ns/1ps
module bigmul_unit_csa #(
    parameter int NUM_LIMBS = 64,
    parameter int PARALLEL  = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [63:0] cycles_out
);

    localparam int NCOL  = 2 * NUM_LIMBS;
    localparam int NPAIR = NUM_LIMBS * NUM_LIMBS;
    localparam int ACC_W = 64 + $clog2(NCOL) + 1;
    localparam int KW    = $clog2(NPAIR + PARALLEL + 1);
    localparam int CW    = $clog2(NCOL);
    localparam int IW    = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;

    // Operand/result storage, loaded and read hierarchically by the host
    logic [63:0] A [0:NUM_LIMBS-1];
    logic [63:0] B [0:NUM_LIMBS-1];
    logic [63:0] R [0:NCOL-1];

    typedef enum logic [2:0] {IDLE, CLEAR, MUL, RESOLVE, DONE} state_t;

    state_t            state_q;
    logic              busy_q, done_q;
    logic [KW-1:0]     k_q;
    logic [CW-1:0]     col_q;
    logic [ACC_W-1:0]  carry_q;
    logic [ACC_W-1:0]  s_q [NCOL];
    logic [ACC_W-1:0]  c_q [NCOL];
    logic [ACC_W-1:0]  s_d [NCOL];
    logic [ACC_W-1:0]  c_d [NCOL];
    logic [ACC_W-1:0]  os, oc, ox;
    logic [ACC_W-1:0]  t;
    logic              last_col;

    logic [PARALLEL-1:0] pv;
    logic [CW-1:0]       plo  [PARALLEL];
    logic [CW-1:0]       phi  [PARALLEL];
    logic [127:0]        prod [PARALLEL];

    // One 64x64 product slot per issued pair k_q+g
    for (genvar g = 0; g < PARALLEL; g++) begin : g_slot
        logic [KW-1:0] kk;
        logic [IW-1:0] ii, jj;
        assign kk      = k_q + KW'(g);
        assign pv[g]   = (kk < KW'(NPAIR));
        assign ii      = IW'(kk / KW'(NUM_LIMBS));
        assign jj      = IW'(kk % KW'(NUM_LIMBS));
        assign prod[g] = 128'(A[ii]) * 128'(B[jj]);
        assign plo[g]  = CW'(ii) + CW'(jj);
        assign phi[g]  = plo[g] + CW'(1);
    end

    always_comb begin
        s_d = s_q;
        c_d = c_q;
        os  = '0;
        oc  = '0;
        ox  = '0;
        if (state_q == CLEAR) begin
            for (int c = 0; c < NCOL; c++) begin
                s_d[c] = '0;
                c_d[c] = '0;
            end
        end else if (state_q == MUL) begin
            // Slots hitting the same column chain through successive 3:2 compressions
            for (int p = 0; p < PARALLEL; p++) begin
                if (pv[p]) begin
                    os = s_d[plo[p]];
                    oc = c_d[plo[p]];
                    ox = ACC_W'(prod[p][63:0]);
                    s_d[plo[p]] = os ^ oc ^ ox;
                    c_d[plo[p]] = ((os & oc) | (os & ox) | (oc & ox)) << 1;
                    os = s_d[phi[p]];
                    oc = c_d[phi[p]];
                    ox = ACC_W'(prod[p][127:64]);
                    s_d[phi[p]] = os ^ oc ^ ox;
                    c_d[phi[p]] = ((os & oc) | (os & ox) | (oc & ox)) << 1;
                end
            end
        end
    end

    // S+C may wrap individually; the true column value plus incoming carry always fits ACC_W
    assign t        = s_q[col_q] + c_q[col_q] + carry_q;
    assign last_col = (col_q == CW'(NCOL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            k_q     <= '0;
            col_q   <= '0;
            carry_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= CLEAR;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    state_q <= MUL;
                    k_q     <= '0;
                    col_q   <= '0;
                    carry_q <= '0;
                end
                MUL: begin
                    k_q <= k_q + KW'(PARALLEL);
                    if (k_q + KW'(PARALLEL) >= KW'(NPAIR))
                        state_q <= RESOLVE;
                end
                RESOLVE: begin
                    col_q   <= col_q + CW'(1);
                    carry_q <= t >> 64;
                    if (last_col) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        s_q <= s_d;
        c_q <= c_d;
        if (state_q == RESOLVE)
            R[col_q] <= t[63:0];
    end

    assign busy = busy_q;
    assign done = done_q;

`ifdef BIGMUL_CYCLE_CNT_EN
    logic [63:0] cnt_q, cyc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            cyc_q <= '0;
        end else begin
            if (state_q == IDLE && start)
                cnt_q <= '0;
            else if (busy_q)
                cnt_q <= cnt_q + 64'd1;
            // Capture includes the final RESOLVE cycle, landing on the same edge as done
            if (state_q == RESOLVE && last_col)
                cyc_q <= cnt_q + 64'd1;
        end
    end

    assign cycles_out = cyc_q;
`else
    assign cycles_out = 64'd0;
`endif

endmodule

// File: tb/tb_bigmul_unit_csa.sv
// Bench for bigmul_unit_csa: three parameterisations checked against a wide-integer
// product model, plus start handling, done pulse, cycle count and async reset behaviour.
`timescale 1ns/1ps
module tb_bigmul_unit_csa;

    localparam int N0 = 64, P0 = 25;
    localparam int N1 = 2,  P1 = 3;
    localparam int N2 = 4,  P2 = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start = '0;
    logic [2:0]  busy, done;
    logic [63:0] cyc [3];

    int n_assert = 0;
    int n_fail   = 0;

    bigmul_unit_csa #(.NUM_LIMBS(N0), .PARALLEL(P0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]), .cycles_out(cyc[0]));
    bigmul_unit_csa #(.NUM_LIMBS(N1), .PARALLEL(P1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]), .cycles_out(cyc[1]));
    bigmul_unit_csa #(.NUM_LIMBS(N2), .PARALLEL(P2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .busy(busy[2]), .done(done[2]), .cycles_out(cyc[2]));

    always #5 clk = ~clk;

    function automatic logic [63:0] exp_cout(input int c);
`ifdef BIGMUL_CYCLE_CNT_EN
        return 64'(c);
`else
        return 64'(c) & 64'd0;
`endif
    endfunction

    function automatic logic [8191:0] ref_mul(input logic [4095:0] a, input logic [4095:0] b);
        logic [8191:0] wa, wb;
        wa = {4096'd0, a};
        wb = {4096'd0, b};
        return wa * wb;
    endfunction

    function automatic logic [4095:0] rvec(input int n);
        logic [4095:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[64*i +: 64] = {$urandom, $urandom};
        return v;
    endfunction

    function automatic logic [4095:0] ones(input int n);
        logic [4095:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[64*i +: 64] = '1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [8191:0] obs, input logic [8191:0] exp);
        int idx;
        idx = 0;
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            for (int i = 127; i >= 0; i--) if (obs[64*i +: 64] !== exp[64*i +: 64]) idx = i;
            $error("FAIL %s: limb %0d observed %h expected %h", tag, idx,
                   obs[64*idx +: 64], exp[64*idx +: 64]);
        end
    endtask

    task automatic load(input int w, input logic [4095:0] a, input logic [4095:0] b);
        case (w)
            0: for (int i = 0; i < N0; i++) begin u0.A[i] = a[64*i +: 64]; u0.B[i] = b[64*i +: 64]; end
            1: for (int i = 0; i < N1; i++) begin u1.A[i] = a[64*i +: 64]; u1.B[i] = b[64*i +: 64]; end
            default: for (int i = 0; i < N2; i++) begin u2.A[i] = a[64*i +: 64]; u2.B[i] = b[64*i +: 64]; end
        endcase
    endtask

    task automatic read_r(input int w, output logic [8191:0] r);
        r = '0;
        case (w)
            0: for (int i = 0; i < 2*N0; i++) r[64*i +: 64] = u0.R[i];
            1: for (int i = 0; i < 2*N1; i++) r[64*i +: 64] = u1.R[i];
            default: for (int i = 0; i < 2*N2; i++) r[64*i +: 64] = u2.R[i];
        endcase
    endtask

    // Pulse start once; mid >= 0 re-pulses start that many cycles into the run
    task automatic run_op(input int w, input int mid, output int nbusy, output bit got_done,
                          output int extra);
        nbusy = 0; got_done = 1'b0; extra = 0;
        @(negedge clk); start[w] = 1'b1;
        @(negedge clk); start[w] = 1'b0;
        for (int t = 0; t < 1000 && !got_done; t++) begin
            if (t == mid) start[w] = 1'b1;
            else if (t == mid + 1) start[w] = 1'b0;
            if (done[w]) begin
                got_done = 1'b1;
                if (busy[w]) extra++;
            end else begin
                if (busy[w]) nbusy++;
                @(negedge clk);
            end
        end
        start[w] = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (done[w] || busy[w]) extra++;
        end
    endtask

    task automatic full_op(input string tag, input int w, input int mid, input logic [4095:0] a,
                           input logic [4095:0] b, input int ecyc, output logic [8191:0] r);
        int  nb, ex;
        bit  gd;
        load(w, a, b);
        run_op(w, mid, nb, gd, ex);
        chk({tag, "_done"}, 64'(gd), 64'd1);
        chk({tag, "_busy_cycles"}, 64'(nb), 64'(ecyc));
        chk({tag, "_one_op"}, 64'(ex), 64'd0);
        chk({tag, "_cycles_out"}, cyc[w], exp_cout(ecyc));
        read_r(w, r);
        chk_vec({tag, "_product"}, r, ref_mul(a, b));
    endtask

    initial begin
        logic [4095:0] a, b;
        logic [8191:0] r;
        int t1, t2, nb;

        repeat (3) @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            chk($sformatf("rst_busy%0d", w), 64'(busy[w]), 64'd0);
            chk($sformatf("rst_done%0d", w), 64'(done[w]), 64'd0);
            chk($sformatf("rst_cyc%0d", w), cyc[w], 64'd0);
        end
        rst_n = 1'b1;

        // Small operands on the default build
        a = '0; b = '0;
        a[63:0] = 64'h38; a[127:64] = 64'h3; b[63:0] = 64'h17;
        full_op("def_small", 0, -1, a, b, 293, r);
        chk("def_small_R0", r[63:0], 64'h508);
        chk("def_small_R1", r[127:64], 64'h45);
        chk("def_small_R2", r[191:128], 64'h0);

        full_op("n2_ones", 1, -1, ones(N1), ones(N1), 7, r);
        chk("n2_R0", r[63:0], 64'h1);
        chk("n2_R1", r[127:64], 64'h0);
        chk("n2_R2", r[191:128], 64'hFFFF_FFFF_FFFF_FFFE);
        chk("n2_R3", r[255:192], 64'hFFFF_FFFF_FFFF_FFFF);

        full_op("def_ones", 0, -1, ones(N0), ones(N0), 293, r);
        chk("def_ones_R0", r[63:0], 64'h1);
        chk("def_ones_R63", r[64*63 +: 64], 64'h0);
        chk("def_ones_R64", r[64*64 +: 64], 64'hFFFF_FFFF_FFFF_FFFE);
        chk("def_ones_R127", r[64*127 +: 64], 64'hFFFF_FFFF_FFFF_FFFF);

        for (int i = 0; i < 3; i++)
            full_op($sformatf("p1_rand%0d", i), 2, -1, rvec(N2), rvec(N2), 25, r);
        full_op("def_rand", 0, -1, rvec(N0), rvec(N0), 293, r);

        // Mid-run start must be ignored
        full_op("p1_midstart", 2, 10, rvec(N2), rvec(N2), 25, r);

        // Start held high: back-to-back ops separated by the DONE and one IDLE cycle
        a = rvec(N1); b = rvec(N1);
        load(1, a, b);
        @(negedge clk); start[1] = 1'b1;
        t1 = -1; t2 = -1; nb = 0;
        for (int t = 0; t < 200 && t2 < 0; t++) begin
            @(negedge clk);
            if (done[1]) begin
                if (t1 < 0) t1 = t; else t2 = t;
            end else if (t1 >= 0 && busy[1]) nb++;
        end
        start[1] = 1'b0;
        chk("held_gap", 64'(t2 - t1), 64'd9);
        chk("held_busy", 64'(nb), 64'd7);
        repeat (3) @(negedge clk);
        chk("held_stop", 64'(busy[1]), 64'd0);
        read_r(1, r);
        chk_vec("held_product", r, ref_mul(a, b));

        // Asynchronous reset in the middle of MUL
        load(0, rvec(N0), rvec(N0));
        @(negedge clk); start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        repeat (40) @(negedge clk);
        chk("arst_pre_busy", 64'(busy[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy[0]), 64'd0);
        chk("arst_done", 64'(done[0]), 64'd0);
        chk("arst_cyc", cyc[0], 64'd0);
        @(negedge clk); rst_n = 1'b1;
        full_op("after_rst", 0, -1, rvec(N0), rvec(N0), 293, r);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
